// File: rtl/stream_pkg.sv
// Shared definitions for the 128-bit beat stream producers.
//   BEAT_W          : width of one output beat.
//   LEGAL_IN_W      : input word widths that divide a beat evenly.
//   in_width_legal(): elaboration-time check that a word width is in that list.
//   state_e         : packer FSM states.
package stream_pkg;

  localparam int BEAT_W = 128;

  localparam int N_LEGAL = 4;
  localparam int LEGAL_IN_W [N_LEGAL] = '{8, 16, 32, 64};

  function automatic bit in_width_legal(input int w);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < N_LEGAL; i++) begin
      if (LEGAL_IN_W[i] == w) ok = 1'b1;
    end
    return ok;
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

endpackage

// File: rtl/stream_pack128_if.sv
// Bundle of all packet-stream signals around stream_pack128.
//   Word side   : sop_in, eop_in, valid_in, data_in (to packer), ready_out (from packer)
//   Beat side   : sop_out, eop_out, valid_out, data_out, last_words (from packer),
//                 ready_in (to packer)
//   Status      : err_out (from packer), sticky framing error
// Modports: slave = the packer, master = whoever drives words / sinks beats.
interface stream_pack128_if
  import stream_pkg::*;
#(
  parameter int IN_WIDTH = 32
);
  localparam int WORDS = BEAT_W / IN_WIDTH;
  localparam int CNT_W = $clog2(WORDS) + 1;

  logic                sop_in;
  logic                eop_in;
  logic                valid_in;
  logic [IN_WIDTH-1:0] data_in;
  logic                ready_out;

  logic                sop_out;
  logic                eop_out;
  logic                valid_out;
  logic [BEAT_W-1:0]   data_out;
  logic [CNT_W-1:0]    last_words;
  logic                ready_in;

  logic                err_out;

  modport slave (
    input  sop_in, eop_in, valid_in, data_in, ready_in,
    output ready_out, sop_out, eop_out, valid_out, data_out, last_words, err_out
  );

  modport master (
    output sop_in, eop_in, valid_in, data_in, ready_in,
    input  ready_out, sop_out, eop_out, valid_out, data_out, last_words, err_out
  );

endinterface

// File: rtl/beat_out_reg.sv
// Output stage for a 128-bit beat producer: one register holding
// data/sop/eop/last_words/valid with a load/drain handshake.
//   clk, rst     : clock, synchronous active-high reset
//   load         : producer writes a new beat this cycle (only when can_load)
//   load_*       : beat contents to write
//   ready_in     : downstream accepts the held beat
//   can_load     : register is empty or draining this cycle
//   valid/data/sop/eop/last_words : registered beat
module beat_out_reg #(
  parameter int DATA_W   = 128,
  parameter int CNT_W    = 3,
  parameter int LAST_RST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_sop,
  input  logic              load_eop,
  input  logic [CNT_W-1:0]  load_last,
  input  logic              ready_in,
  output logic              can_load,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              sop,
  output logic              eop,
  output logic [CNT_W-1:0]  last_words
);

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic              sop_p1;
  logic              eop_p1;
  logic [CNT_W-1:0]  last_p1;

  // A new beat may enter while the old one leaves (back-to-back beats).
  assign can_load = !vld_p1 || ready_in;

  // ---- stage p1: output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sop_p1  <= 1'b0;
      eop_p1  <= 1'b0;
      last_p1 <= CNT_W'(LAST_RST);
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= load_data;
      sop_p1  <= load_sop;
      eop_p1  <= load_eop;
      last_p1 <= load_last;
    end else if (vld_p1 && ready_in) begin
      vld_p1  <= 1'b0;
    end
  end

  assign valid      = vld_p1;
  assign data       = data_p1;
  assign sop        = sop_p1;
  assign eop        = eop_p1;
  assign last_words = last_p1;

endmodule

// File: rtl/stream_pack128.sv
// Packs a packet-framed IN_WIDTH-bit word stream into 128-bit beats, LSB-first
// (earliest word in data_out[IN_WIDTH-1:0]). Partial final beats are
// zero-padded and report their word count on last_words.
//   clk, rst : clock, synchronous active-high reset
//   bus      : stream_pack128_if.slave (word input, beat output, err_out)
module stream_pack128
  import stream_pkg::*;
#(
  parameter int IN_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  stream_pack128_if.slave bus
);

  localparam int WORDS = BEAT_W / IN_WIDTH;
  localparam int CNT_W = $clog2(WORDS) + 1;
  localparam int IDX_W = $clog2(WORDS);

  if (!in_width_legal(IN_WIDTH)) begin : g_bad_width
    $error("stream_pack128: IN_WIDTH %0d must be 8, 16, 32 or 64", IN_WIDTH);
  end

  // Word `word` placed into slot `idx` of `base`, other slots untouched.
  function automatic logic [BEAT_W-1:0] insert_word(
    input logic [BEAT_W-1:0]   base,
    input logic [IDX_W-1:0]    idx,
    input logic [IN_WIDTH-1:0] word
  );
    logic [BEAT_W-1:0] r;
    r = base;
    for (int i = 0; i < WORDS; i++) begin
      if (IDX_W'(i) == idx) r[i*IN_WIDTH +: IN_WIDTH] = word;
    end
    return r;
  endfunction

  state_e            state, state_d;
  logic [BEAT_W-1:0] asm_data, asm_data_d;
  logic [IDX_W-1:0]  asm_cnt, asm_cnt_d;
  logic              asm_sop, asm_sop_d;
  logic              err, err_d;

  logic              can_load;
  logic              accept;
  logic              start_pkt;
  logic [IDX_W-1:0]  slot_idx;
  logic [BEAT_W-1:0] ins_data;
  logic              close_beat;

  logic              load;
  logic [BEAT_W-1:0] ld_data;
  logic              ld_sop;
  logic              ld_eop;
  logic [CNT_W-1:0]  ld_last;

  assign bus.ready_out = !rst && can_load;
  assign accept        = bus.valid_in && bus.ready_out;

  // Any sop restarts assembly at slot 0 on a clean (zero) beat, which is
  // also what drops the partial words of an interrupted packet.
  assign start_pkt  = bus.sop_in;
  assign slot_idx   = start_pkt ? '0 : asm_cnt;
  assign ins_data   = insert_word(start_pkt ? '0 : asm_data, slot_idx, bus.data_in);
  assign close_beat = bus.eop_in || (slot_idx == IDX_W'(WORDS - 1));

  always_comb begin
    state_d    = state;
    asm_data_d = asm_data;
    asm_cnt_d  = asm_cnt;
    asm_sop_d  = asm_sop;
    err_d      = err;
    load       = 1'b0;
    ld_data    = ins_data;
    ld_sop     = start_pkt || asm_sop;
    ld_eop     = bus.eop_in;
    ld_last    = {1'b0, slot_idx} + CNT_W'(1);

    if (accept) begin
      if (state == ST_IDLE && !start_pkt) begin
        // Orphan word between packets: discard.
        err_d = 1'b1;
      end else begin
        if (state == ST_FILL && start_pkt) err_d = 1'b1;
        if (close_beat) begin
          load       = 1'b1;
          asm_data_d = '0;
          asm_cnt_d  = '0;
          asm_sop_d  = 1'b0;
          // A full beat without eop keeps the packet open.
          state_d    = bus.eop_in ? ST_IDLE : ST_FILL;
        end else begin
          asm_data_d = ins_data;
          asm_cnt_d  = slot_idx + IDX_W'(1);
          asm_sop_d  = start_pkt || asm_sop;
          state_d    = ST_FILL;
        end
      end
    end
  end

  // ---- stage p0: assembly register and FSM ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      asm_data <= '0;
      asm_cnt  <= '0;
      asm_sop  <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      asm_data <= asm_data_d;
      asm_cnt  <= asm_cnt_d;
      asm_sop  <= asm_sop_d;
      err      <= err_d;
    end
  end

  assign bus.err_out = err;

  beat_out_reg #(
    .DATA_W  (BEAT_W),
    .CNT_W   (CNT_W),
    .LAST_RST(WORDS)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (ld_data),
    .load_sop  (ld_sop),
    .load_eop  (ld_eop),
    .load_last (ld_last),
    .ready_in  (bus.ready_in),
    .can_load  (can_load),
    .valid     (bus.valid_out),
    .data      (bus.data_out),
    .sop       (bus.sop_out),
    .eop       (bus.eop_out),
    .last_words(bus.last_words)
  );

endmodule

// File: tb/tb_stream_pack128.sv
// Bench for stream_pack128 (IN_WIDTH=32, four words per beat). Expected beats
// are computed from each packet's word list and queued before it is driven;
// a negedge monitor pops and compares every transferred beat.
module tb_stream_pack128;

  localparam int W     = 32;
  localparam int WORDS = 4;

  typedef struct packed {
    logic [127:0] data;
    logic         sop;
    logic         eop;
    logic [2:0]   last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;

  stream_pack128_if #(.IN_WIDTH(W)) bus ();

  stream_pack128 #(.IN_WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  beat_t        exp_q[$];
  logic [W-1:0] pkt[$];
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected beats for the packet in pkt, built by chunking its word list.
  task automatic push_expected();
    beat_t b;
    int    n;
    n = pkt.size();
    for (int base = 0; base < n; base += WORDS) begin
      b.data = '0;
      b.last = 3'd0;
      for (int k = 0; k < WORDS && base + k < n; k++) begin
        b.data[k*W +: W] = pkt[base+k];
        b.last = b.last + 3'd1;
      end
      b.sop = (base == 0);
      b.eop = (base + WORDS >= n);
      exp_q.push_back(b);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the word was accepted.
  task automatic send_word(input logic sop, input logic eop, input logic [W-1:0] d);
    logic r;
    int   t;
    bus.valid_in = 1'b1;
    bus.sop_in   = sop;
    bus.eop_in   = eop;
    bus.data_in  = d;
    t = 0;
    do begin
      @(negedge clk);
      r = bus.ready_out;
      @(posedge clk);
      t++;
    end while (!r && t < 100);
    #1;
    check("send_timeout", 128'(r), 128'(1));
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      send_word(i == 0, i == pkt.size() - 1, pkt[i]);
  endtask

  task automatic idle(input int n);
    bus.valid_in = 1'b0;
    bus.sop_in   = 1'b0;
    bus.eop_in   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int t;
    bus.valid_in = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    repeat (6) @(posedge clk);
    #1;
    check(tag, 128'(exp_q.size()), 128'(0));
  endtask

  // Beat monitor: a transfer happens at the next posedge when both are high.
  always @(negedge clk) begin
    beat_t e;
    if (!rst && bus.valid_out && bus.ready_in) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        assert (0) else begin
          n_err++;
          $error("FAIL unexpected_beat: observed data %h expected no beat", bus.data_out);
        end
      end else begin
        e = exp_q.pop_front();
        check("beat_data", bus.data_out, e.data);
        check("beat_sop", 128'(bus.sop_out), 128'(e.sop));
        check("beat_eop", 128'(bus.eop_out), 128'(e.eop));
        check("beat_last", 128'(bus.last_words), 128'(e.last));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] held;

    rst          = 1'b1;
    bus.valid_in = 1'b0;
    bus.sop_in   = 1'b0;
    bus.eop_in   = 1'b0;
    bus.data_in  = '0;
    bus.ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_ready_out", 128'(bus.ready_out), 128'(0));
    check("rst_valid_out", 128'(bus.valid_out), 128'(0));
    check("rst_err_out", 128'(bus.err_out), 128'(0));
    check("rst_data_out", bus.data_out, 128'(0));
    check("rst_sop_eop", 128'({bus.sop_out, bus.eop_out}), 128'(0));
    check("rst_last_words", 128'(bus.last_words), 128'(WORDS));
    rst = 1'b0;
    #1;
    check("ready_after_rst", 128'(bus.ready_out), 128'(1));

    // 1: single-word packet, one-cycle latency
    pkt = '{32'hA5A5A5A5};
    push_expected();
    send_range(0, 0);
    check("t1_latency_valid", 128'(bus.valid_out), 128'(1));
    idle(1);
    check("t1_single_beat", 128'(bus.valid_out), 128'(0));
    wait_drain("t1_drain");

    // 2: six-word packet
    pkt = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    push_expected();
    send_range(0, 5);
    wait_drain("t2_drain");

    // 3: eight-word packet, exactly two beats
    pkt = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88};
    push_expected();
    send_range(0, 7);
    wait_drain("t3_drain");
    check("t3_err_clean", 128'(bus.err_out), 128'(0));

    // 4: backpressure for 5 cycles after the first beat appears
    pkt = '{32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5, 32'hB6, 32'hB7, 32'hB8};
    push_expected();
    bus.ready_in = 1'b0;
    send_range(0, 3);
    check("t4_beat_present", 128'(bus.valid_out), 128'(1));
    held = bus.data_out;
    bus.valid_in = 1'b1;
    bus.sop_in   = 1'b0;
    bus.eop_in   = 1'b0;
    bus.data_in  = pkt[4];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t4_ready_out_low", 128'(bus.ready_out), 128'(0));
      check("t4_data_stable", bus.data_out, held);
      @(posedge clk);
      #1;
    end
    bus.ready_in = 1'b1;
    send_range(4, 7);
    wait_drain("t4_drain");

    // 5a: word without sop in IDLE is dropped and flags an error
    send_word(1'b0, 1'b0, 32'hDEAD0001);
    idle(1);
    check("t5a_err_set", 128'(bus.err_out), 128'(1));
    wait_drain("t5a_no_beat");

    // 5b: sop after two words: partial dropped, new packet intact
    send_word(1'b1, 1'b0, 32'hBAD00001);
    send_word(1'b0, 1'b0, 32'hBAD00002);
    pkt = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
    push_expected();
    send_range(0, 3);
    wait_drain("t5b_drain");
    check("t5b_err_sticky", 128'(bus.err_out), 128'(1));

    // 6: reset after three accepted words
    send_word(1'b1, 1'b0, 32'hE0);
    send_word(1'b0, 1'b0, 32'hE1);
    send_word(1'b0, 1'b0, 32'hE2);
    bus.valid_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t6_ready_in_rst", 128'(bus.ready_out), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_valid_out", 128'(bus.valid_out), 128'(0));
    check("t6_err_cleared", 128'(bus.err_out), 128'(0));
    pkt = '{32'hF0, 32'hF1, 32'hF2, 32'hF3};
    push_expected();
    send_range(0, 3);
    wait_drain("t6_drain");
    check("t6_err_clean", 128'(bus.err_out), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
